// File: rtl/connect4_turn_arbiter.sv
// connect4_turn_arbiter: alternates two player channels onto the engine op channel,
// forwards engine responses to the host and keeps win/tie scores.
module connect4_turn_arbiter #(
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               p0_valid,
    output logic               p0_ready,
    input  logic [2:0]         p0_col,
    input  logic               p1_valid,
    output logic               p1_ready,
    input  logic [2:0]         p1_col,
    input  logic               op_ready,
    output logic               op_valid,
    output logic               op_player_id,
    output logic [2:0]         op_col_id,
    output logic               re_ready,
    input  logic               re_valid,
    input  logic               re_err,
    input  logic               re_is_finished,
    input  logic               re_winner,
    input  logic               re_tie,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_player,
    output logic               res_err,
    output logic               res_finished,
    output logic               res_winner,
    output logic               res_tie,
    output logic               turn,
    output logic [SCORE_W-1:0] win0,
    output logic [SCORE_W-1:0] win1,
    output logic [SCORE_W-1:0] ties
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RE, REPORT} state_t;
    localparam logic [SCORE_W-1:0] MAX = '1;

    state_t state_q, state_d;
    logic p0_ready_q, p0_ready_d, p1_ready_q, p1_ready_d;
    logic op_valid_q, op_valid_d, op_player_q, op_player_d;
    logic [2:0] op_col_q, op_col_d;
    logic re_ready_q, re_ready_d, res_valid_q, res_valid_d;
    logic res_player_q, res_player_d, res_err_q, res_err_d, res_fin_q, res_fin_d;
    logic res_win_q, res_win_d, res_tie_q, res_tie_d, turn_q, turn_d;
    logic [SCORE_W-1:0] win0_q, win0_d, win1_q, win1_d, ties_q, ties_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            p0_ready_q   <= 1'b1;
            p1_ready_q   <= 1'b0;
            op_valid_q   <= 1'b0;
            op_player_q  <= 1'b0;
            op_col_q     <= 3'd0;
            re_ready_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            res_player_q <= 1'b0;
            res_err_q    <= 1'b0;
            res_fin_q    <= 1'b0;
            res_win_q    <= 1'b0;
            res_tie_q    <= 1'b0;
            turn_q       <= 1'b0;
            win0_q       <= '0;
            win1_q       <= '0;
            ties_q       <= '0;
        end else begin
            state_q      <= state_d;
            p0_ready_q   <= p0_ready_d;
            p1_ready_q   <= p1_ready_d;
            op_valid_q   <= op_valid_d;
            op_player_q  <= op_player_d;
            op_col_q     <= op_col_d;
            re_ready_q   <= re_ready_d;
            res_valid_q  <= res_valid_d;
            res_player_q <= res_player_d;
            res_err_q    <= res_err_d;
            res_fin_q    <= res_fin_d;
            res_win_q    <= res_win_d;
            res_tie_q    <= res_tie_d;
            turn_q       <= turn_d;
            win0_q       <= win0_d;
            win1_q       <= win1_d;
            ties_q       <= ties_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        p0_ready_d   = p0_ready_q;
        p1_ready_d   = p1_ready_q;
        op_valid_d   = op_valid_q;
        op_player_d  = op_player_q;
        op_col_d     = op_col_q;
        re_ready_d   = re_ready_q;
        res_valid_d  = res_valid_q;
        res_player_d = res_player_q;
        res_err_d    = res_err_q;
        res_fin_d    = res_fin_q;
        res_win_d    = res_win_q;
        res_tie_d    = res_tie_q;
        turn_d       = turn_q;
        win0_d       = win0_q;
        win1_d       = win1_q;
        ties_d       = ties_q;
        case (state_q)
            IDLE: if ((p0_valid && p0_ready_q) || (p1_valid && p1_ready_q)) begin
                op_player_d = p1_ready_q;
                op_col_d    = p1_ready_q ? p1_col : p0_col;
                op_valid_d  = 1'b1;
                p0_ready_d  = 1'b0;
                p1_ready_d  = 1'b0;
                state_d     = ISSUE;
            end
            ISSUE: if (op_ready) begin
                op_valid_d = 1'b0;
                re_ready_d = 1'b1;
                state_d    = WAIT_RE;
            end
            WAIT_RE: if (re_valid) begin
                res_err_d    = re_err;
                res_fin_d    = re_is_finished;
                res_win_d    = re_winner;
                res_tie_d    = re_tie;
                res_player_d = op_player_q;
                re_ready_d   = 1'b0;
                res_valid_d  = 1'b1;
                state_d      = REPORT;
                // An illegal move leaves turn and scores alone so the same player retries
                if (!re_err) begin
                    turn_d = re_is_finished ? 1'b0 : !turn_q;
                    if (re_is_finished && re_tie)
                        ties_d = (ties_q == MAX) ? ties_q : ties_q + 1'b1;
                    else if (re_is_finished && re_winner)
                        win1_d = (win1_q == MAX) ? win1_q : win1_q + 1'b1;
                    else if (re_is_finished)
                        win0_d = (win0_q == MAX) ? win0_q : win0_q + 1'b1;
                end
            end
            REPORT: if (res_ready) begin
                res_valid_d  = 1'b0;
                res_player_d = 1'b0;
                res_err_d    = 1'b0;
                res_fin_d    = 1'b0;
                res_win_d    = 1'b0;
                res_tie_d    = 1'b0;
                p0_ready_d   = !turn_q;
                p1_ready_d   = turn_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign p0_ready     = p0_ready_q;
    assign p1_ready     = p1_ready_q;
    assign op_valid     = op_valid_q;
    assign op_player_id = op_player_q;
    assign op_col_id    = op_col_q;
    assign re_ready     = re_ready_q;
    assign res_valid    = res_valid_q;
    assign res_player   = res_player_q;
    assign res_err      = res_err_q;
    assign res_finished = res_fin_q;
    assign res_winner   = res_win_q;
    assign res_tie      = res_tie_q;
    assign turn         = turn_q;
    assign win0         = win0_q;
    assign win1         = win1_q;
    assign ties         = ties_q;
endmodule

// File: tb/tb_connect4_turn_arbiter.sv
// tb_connect4_turn_arbiter: directed checks of turn order, result forwarding,
// scoring/saturation (SCORE_W=2) and asynchronous reset.
module tb_connect4_turn_arbiter;
    logic clk = 0, rst = 1;
    logic p0_valid = 0, p1_valid = 0, op_ready = 0, re_valid = 0, res_ready = 0;
    logic [2:0] p0_col = 0, p1_col = 0;
    logic re_err = 0, re_is_finished = 0, re_winner = 0, re_tie = 0;
    logic p0_ready, p1_ready, op_valid, op_player_id, re_ready, res_valid;
    logic [2:0] op_col_id;
    logic res_player, res_err, res_finished, res_winner, res_tie, turn;
    logic [1:0] win0, win1, ties;
    int total = 0, bad = 0;
    logic t_m = 0;
    int w0_m = 0, w1_m = 0, ti_m = 0;

    connect4_turn_arbiter #(.SCORE_W(2)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_col(p0_col),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_col(p1_col),
        .op_ready(op_ready), .op_valid(op_valid), .op_player_id(op_player_id), .op_col_id(op_col_id),
        .re_ready(re_ready), .re_valid(re_valid), .re_err(re_err), .re_is_finished(re_is_finished),
        .re_winner(re_winner), .re_tie(re_tie),
        .res_valid(res_valid), .res_ready(res_ready), .res_player(res_player), .res_err(res_err),
        .res_finished(res_finished), .res_winner(res_winner), .res_tie(res_tie),
        .turn(turn), .win0(win0), .win1(win1), .ties(ties)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v == 3) ? 3 : v + 1;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_turn"}, turn, t_m);
        chk({tag, "_p0rdy"}, p0_ready, !t_m);
        chk({tag, "_p1rdy"}, p1_ready, t_m);
        chk({tag, "_win0"}, win0, w0_m[7:0]);
        chk({tag, "_win1"}, win1, w1_m[7:0]);
        chk({tag, "_ties"}, ties, ti_m[7:0]);
    endtask

    // Full move round trip at negedge boundaries; the bench plays the engine
    task automatic play(input logic p, input logic [2:0] col, input logic e, input logic f,
                        input logic w, input logic t, input logic hold, input int stall);
        int n = 0;
        if (p) begin p1_valid = 1; p1_col = col; end
        else   begin p0_valid = 1; p0_col = col; end
        while (!(p ? p1_ready : p0_ready) && n < 50) begin @(negedge clk); n++; end
        chk("accept_wait", (n < 50), 1);
        @(negedge clk);
        if (!hold) begin p0_valid = 0; p1_valid = 0; end
        chk("op_valid", op_valid, 1);
        chk("op_player", op_player_id, p);
        chk("op_col", op_col_id, col);
        chk("rdy_busy", {p0_ready, p1_ready}, 0);
        op_ready = 1;
        @(negedge clk);
        op_ready = 0;
        chk("op_done", {op_valid, re_ready}, 2'b01);
        re_valid = 1; re_err = e; re_is_finished = f; re_winner = w; re_tie = t;
        @(negedge clk);
        re_valid = 0; re_err = 0; re_is_finished = 0; re_winner = 0; re_tie = 0;
        if (!e) begin
            if (f) begin
                if (t) ti_m = sat(ti_m);
                else if (w) w1_m = sat(w1_m);
                else w0_m = sat(w0_m);
                t_m = 0;
            end else t_m = !t_m;
        end
        for (int i = 0; i <= stall; i++) begin
            chk("res_valid", res_valid, 1);
            chk("res_fields", {res_player, res_err, res_finished, res_winner, res_tie}, {p, e, f, w, t});
            chk("quiet", {re_ready, op_valid, p0_ready, p1_ready}, 0);
            if (i < stall) @(negedge clk);
        end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        chk("res_clear", {res_valid, res_player, res_err, res_finished, res_winner, res_tie}, 0);
        check_idle("idle");
    endtask

    initial begin
        @(negedge clk);
        chk("rst_p0rdy", p0_ready, 1);
        chk("rst_outs", {p1_ready, op_valid, re_ready, res_valid, turn}, 0);
        chk("rst_cnt", {win0, win1, ties}, 0);
        rst = 0;
        @(negedge clk);
        // first move, then held simultaneous requests must alternate
        play(0, 3, 0, 0, 0, 0, 0, 0);
        p0_valid = 1; p1_valid = 1;
        play(1, 5, 0, 0, 0, 0, 1, 0);
        play(0, 4, 0, 0, 0, 0, 1, 0);
        play(1, 5, 0, 0, 0, 0, 1, 0);
        play(0, 4, 0, 0, 0, 0, 1, 0);
        p0_valid = 0; p1_valid = 0;
        // six moves into column 2, then a seventh is rejected and the same player retries
        for (int i = 0; i < 6; i++) play(t_m, 2, 0, 0, 0, 0, 0, 0);
        play(1, 2, 1, 0, 0, 0, 0, 0);
        play(1, 7, 0, 0, 0, 0, 0, 0);
        rst = 1;
        @(negedge clk);
        rst = 0; t_m = 0; w0_m = 0; w1_m = 0; ti_m = 0;
        check_idle("rst2");
        // vertical win for player 0 on the 7th move, with a stalled host on the last result
        for (int i = 0; i < 3; i++) begin
            play(0, 0, 0, 0, 0, 0, 0, 0);
            play(1, 1, 0, 0, 0, 0, 0, 0);
        end
        play(0, 0, 0, 1, 0, 0, 0, 10);
        // four player-1 wins saturate the 2-bit counter; one tie
        for (int g = 0; g < 4; g++) begin
            play(0, 3, 0, 0, 0, 0, 0, 0);
            play(1, 4, 0, 1, 1, 0, 0, 0);
        end
        play(0, 6, 0, 1, 0, 1, 0, 0);
        // asynchronous reset while a player-1 move sits in ISSUE
        play(0, 4, 0, 0, 0, 0, 0, 0);
        p1_valid = 1; p1_col = 6;
        @(negedge clk);
        p1_valid = 0;
        chk("issue_op_valid", op_valid, 1);
        #2 rst = 1;
        #1;
        chk("arst_op_valid", op_valid, 0);
        chk("arst_turn", turn, 0);
        chk("arst_rdy", {p0_ready, p1_ready}, 2'b10);
        chk("arst_cnt", {win0, win1, ties}, 0);
        @(negedge clk);
        rst = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/connect4_turn_arbiter.md
Name: connect4_turn_arbiter

Overview:
- Upstream stage of the connect-four game engine.
- Accepts column requests from two independent player channels and enforces strict turn alternation, starting with player 0.
- Issues one move at a time on the engine's op channel, then collects the engine's response and forwards it to a single result channel.
- Keeps per-player win counters and a tie counter.

Parameters:
SCORE_W, 8, width of the win0/win1/tie counters; counters saturate at 2^SCORE_W-1.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
p0_valid  in  1  player 0 has a column request
p0_ready  out  1  player 0 request accepted when p0_valid&p0_ready
p0_col  in  3  player 0 column, 0..6 (7 is forwarded unchanged)
p1_valid  in  1  player 1 has a column request
p1_ready  out  1  player 1 request accepted when p1_valid&p1_ready
p1_col  in  3  player 1 column
op_ready  in  1  engine can take a move
op_valid  out  1  move presented to engine
op_player_id  out  1  player of presented move
op_col_id  out  3  column of presented move
re_ready  out  1  arbiter ready for engine response
re_valid  in  1  engine response valid
re_err  in  1  engine: illegal move (column full)
re_is_finished  in  1  engine: game over
re_winner  in  1  engine: winning player
re_tie  in  1  engine: board full, no winner
res_valid  out  1  result available to host
res_ready  in  1  host accepts result
res_player  out  1  player whose move produced this result
res_err  out  1  copy of re_err
res_finished  out  1  copy of re_is_finished
res_winner  out  1  copy of re_winner
res_tie  out  1  copy of re_tie
turn  out  1  player whose move is currently expected
win0  out  SCORE_W  games won by player 0
win1  out  SCORE_W  games won by player 1
ties  out  SCORE_W  tied games

Behaviour:
- Reset (rst=1, asynchronous): state IDLE; turn=0.
  - p0_ready=1 (IDLE with turn 0); all other outputs 0; counters 0.
  - Engine shares this reset, so a reset in any state abandons the move with no handshake completion.
- All handshake outputs are registered; valid/data outputs are held stable until the corresponding fire.
- State IDLE:
  - p0_ready = (turn==0); p1_ready = (turn==1). The off-turn player's ready is always 0, so its request waits without being dropped.
  - On a fire of the on-turn player: latch player and column into op_player_id/op_col_id, set op_valid=1, clear both p*_ready, go to ISSUE.
  - The request reaches op_valid on the cycle after acceptance.
- State ISSUE: hold op_valid. On op_valid&op_ready: op_valid=0, re_ready=1, go to WAIT_RE.
- State WAIT_RE:
  - On re_valid&re_ready: latch re_err/re_is_finished/re_winner/re_tie into res_*; res_player=op_player_id; re_ready=0; res_valid=1; go to REPORT.
  - Update turn and counters on this same edge:
    - re_err=1: turn unchanged (same player retries); counters unchanged.
    - re_is_finished=1 & re_tie=0: increment win0 or win1 per re_winner, saturating; turn=0.
    - re_is_finished=1 & re_tie=1: increment ties, saturating; turn=0.
    - Otherwise: turn toggles.
- State REPORT: hold res_*. On res_valid&res_ready: res_valid=0, clear res_* data to 0, go to IDLE with p*_ready per the new turn.
- Minimum round trip with all partners always ready: accept (C0) → op fire (C1) → response depends on engine → result fire → IDLE next cycle.
- Simultaneous valids from both players: only the on-turn player is accepted.
- Engine re_valid outside WAIT_RE: ignored, since re_ready=0.
- Counters never wrap. Saturated value holds at 2^SCORE_W-1.

Test Plan:
- Reset then p0_valid=1, p0_col=3, with engine ready → op_valid=1, op_player_id=0, op_col_id=3 the cycle after p0 fire; after result fire, turn=1 and p1_ready=1, p0_ready=0.
- p0_valid and p1_valid both held high, turn=0 → only p0 accepted; after p0's result, p1 accepted; sequence alternates 0,1,0,1.
- Fill column 2 (six moves), then turn-owner sends col 2 → res_err=1; turn unchanged; same player's p*_ready=1 again; counters unchanged.
- Player 0 plays cols 0,0,0,0 while player 1 plays cols 1,1,1 → on 7th result res_finished=1, res_winner=0, win0=1, turn=0.
- Hold res_ready=0 for 10 cycles in REPORT → res_* stable; p0_ready=p1_ready=0; op_valid=0 throughout.
- SCORE_W=2, force four player-1 wins → win1 saturates at 3. Assert rst in ISSUE → op_valid=0 and turn=0 asynchronously, p0_ready=1.
